// File: rtl/bcd_time_display_scanner_if.sv
// ---------------------------------------------------------------------------
// bcd_time_display_scanner_if
// Purpose: bundles the time-digit inputs and 7-segment display outputs of the
//          BCD time display scanner.
// Signals:
//   en                     display enable (low blanks and freezes scanning)
//   s1,s2,m1,m2,h1,h2      BCD digits HH:MM:SS (s1 = seconds units)
//   seg[6:0]               segments {g,f,e,d,c,b,a}, active-low
//   dp                     decimal point, active-low
//   anode[5:0]             digit select, active-low, bit i = digit index i
//   err                    sticky illegal-BCD flag
// Modports: master drives en/digits and observes the display,
//           slave is the scanner side.
// ---------------------------------------------------------------------------
interface bcd_time_display_scanner_if;
  logic       en;
  logic [3:0] s1;
  logic [3:0] s2;
  logic [3:0] m1;
  logic [3:0] m2;
  logic [3:0] h1;
  logic [3:0] h2;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] anode;
  logic       err;

  modport master (
    output en, s1, s2, m1, m2, h1, h2,
    input  seg, dp, anode, err
  );

  modport slave (
    input  en, s1, s2, m1, m2, h1, h2,
    output seg, dp, anode, err
  );
endinterface

// File: rtl/bcd_time_display_scanner.sv
// ---------------------------------------------------------------------------
// bcd_time_display_scanner
// Purpose: scans six BCD time digits onto a multiplexed common-anode 6-digit
//          7-segment display. A snapshot of all digits is taken once per scan
//          frame so a counter rollover never shows a torn time. The colon
//          decimal points (digit indices 2 and 4) flash every BLINK_FRAMES
//          frames, and an illegal BCD capture raises a sticky err flag.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    bcd_time_display_scanner_if.slave (en, digits in; seg/dp/anode/err)
// Parameters:
//   SCAN_DIV      clk cycles each digit stays lit (>=2)
//   BLINK_FRAMES  full frames between colon toggles (>=1)
// Optional build macro:
//   LEADING_ZERO_BLANK_EN  blanks the leftmost digit when the hours tens is 0
// ---------------------------------------------------------------------------
module bcd_time_display_scanner #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 100
) (
  input  logic                        clk,
  input  logic                        rst_n,
  bcd_time_display_scanner_if.slave   bus
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [5:0] AN_OFF  = 6'b111111;

  // Active-low {g..a} decode; anything above 9 shows a dash.
  function automatic logic [6:0] dec7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  // True when any nibble of the packed time word is not a legal BCD digit.
  function automatic logic any_illegal(input logic [23:0] t);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bad = bad | (t[4*i +: 4] > 4'd9);
    end
    return bad;
  endfunction

  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             blink_q, blink_d;
  logic [23:0]      snap_q, snap_d;     // {h2,h1,m2,m1,s2,s1}
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [5:0]       anode_q, anode_d;
  logic             err_q, err_d;

  logic             tick_s;
  logic             wrap_s;
  logic [3:0]       digit_s;
  logic             blank_lz_s;

  // Digit currently selected by the scan index.
  always_comb begin
    case (idx_q)
      3'd0:    digit_s = snap_q[3:0];
      3'd1:    digit_s = snap_q[7:4];
      3'd2:    digit_s = snap_q[11:8];
      3'd3:    digit_s = snap_q[15:12];
      3'd4:    digit_s = snap_q[19:16];
      3'd5:    digit_s = snap_q[23:20];
      default: digit_s = 4'd0;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign blank_lz_s = (idx_q == 3'd5) && (digit_s == 4'd0);
`else
  assign blank_lz_s = 1'b0;
`endif

  assign tick_s = bus.en && (div_q == DIV_W'(SCAN_DIV - 1));
  assign wrap_s = tick_s && (idx_q == 3'd5);

  // Next-state for the scan divider, digit index, frame/blink counters,
  // snapshot and sticky error flag.
  always_comb begin
    div_d       = div_q;
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    snap_d      = snap_q;
    if (!bus.en) begin
      div_d = div_q;
    end else if (tick_s) begin
      div_d = '0;
      if (wrap_s) begin
        idx_d  = 3'd0;
        snap_d = {bus.h2, bus.h1, bus.m2, bus.m1, bus.s2, bus.s1};
        if (frame_cnt_q == FRM_W'(BLINK_FRAMES - 1)) begin
          frame_cnt_d = '0;
          blink_d     = ~blink_q;
        end else begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end else begin
      div_d = div_q + 1'b1;
    end
    // err rises one edge after the snapshot that carried the bad digit.
    err_d = err_q | any_illegal(snap_q);
  end

  // Display drive computed from the current index/snapshot; registered below
  // so the pins update one cycle after the scan state.
  always_comb begin
    anode_d = AN_OFF;
    seg_d   = SEG_OFF;
    dp_d    = 1'b1;
    if (!bus.en) begin
      anode_d = AN_OFF;
    end else if (blank_lz_s) begin
      anode_d = ~(6'b000001 << idx_q);
    end else begin
      anode_d = ~(6'b000001 << idx_q);
      seg_d   = dec7(digit_s);
      dp_d    = ~(blink_q && ((idx_q == 3'd2) || (idx_q == 3'd4)));
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= '0;
      idx_q       <= 3'd0;
      frame_cnt_q <= '0;
      blink_q     <= 1'b0;
      snap_q      <= 24'd0;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
      anode_q     <= AN_OFF;
      err_q       <= 1'b0;
    end else begin
      div_q       <= div_d;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
      snap_q      <= snap_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      anode_q     <= anode_d;
      err_q       <= err_d;
    end
  end

  assign bus.seg   = seg_q;
  assign bus.dp    = dp_q;
  assign bus.anode = anode_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_bcd_time_display_scanner.sv
// ---------------------------------------------------------------------------
// tb_bcd_time_display_scanner
// Directed bench for bcd_time_display_scanner with SCAN_DIV=4, BLINK_FRAMES=2.
// Each digit is lit for 4 cycles, so one frame is 24 cycles. Outputs are
// sampled 2 time units after the rising edge.
// ---------------------------------------------------------------------------
module tb_bcd_time_display_scanner;

  localparam logic [6:0] D0   = 7'b1000000;
  localparam logic [6:0] D1   = 7'b1111001;
  localparam logic [6:0] D2   = 7'b0100100;
  localparam logic [6:0] D3   = 7'b0110000;
  localparam logic [6:0] D4   = 7'b0011001;
  localparam logic [6:0] D5   = 7'b0010010;
  localparam logic [6:0] D9   = 7'b0010000;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] OFF  = 7'b1111111;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  bcd_time_display_scanner_if bus ();

  bcd_time_display_scanner #(
    .SCAN_DIV     (4),
    .BLINK_FRAMES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [23:0] t);
    {bus.h2, bus.h1, bus.m2, bus.m1, bus.s2, bus.s1} = t;
  endtask

  // Walk digit indices first..last of a frame, checking anode/seg/dp on the
  // first cycle of each digit and that anode holds through its 4th cycle.
  task automatic run_frame(input string fr, input logic [41:0] exp_seg,
                           input logic [5:0] dp_lo, input int first, input int last,
                           input int chg_idx, input logic [23:0] chg_val);
    logic [5:0] an;
    logic [6:0] sg;
    logic       dpe;
    for (int k = first; k <= last; k++) begin
      an  = ~(6'b000001 << k);
      sg  = exp_seg[7*k +: 7];
      dpe = ~dp_lo[k];
      step(1);
      chk($sformatf("%s_anode%0d", fr, k), bus.anode, an);
      chk($sformatf("%s_seg%0d", fr, k), bus.seg, sg);
      chk($sformatf("%s_dp%0d", fr, k), bus.dp, dpe);
      if (k == chg_idx) drive(chg_val);
      step(3);
      chk($sformatf("%s_hold%0d", fr, k), bus.anode, an);
    end
  endtask

  initial begin
    logic [6:0] lz_exp;
    total  = 0;
    bad    = 0;
    rst_n  = 1'b1;
    bus.en = 1'b0;
    drive(24'h000000);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_anode", bus.anode, 6'b111111);
    chk("rst_seg", bus.seg, OFF);
    chk("rst_dp", bus.dp, 1'b1);
    chk("rst_err", bus.err, 1'b0);

    // Release, scan partway, then reset mid-frame.
    @(negedge clk);
    rst_n  = 1'b1;
    bus.en = 1'b1;
    step(1);
    chk("first_anode", bus.anode, 6'b111110);
    step(6);
    rst_n = 1'b0;
    #1;
    chk("midrst_anode", bus.anode, 6'b111111);
    chk("midrst_seg", bus.seg, OFF);
    chk("midrst_err", bus.err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(24'h123459);

    // Frame 0: reset snapshot 00:00:00 even though inputs already changed.
    run_frame("f0", {D0, D0, D0, D0, D0, D0}, 6'b000000, 0, 5, -1, 24'h0);
    // Frame 1: 12:34:59; inputs change to 12:35:00 during idx 3.
    run_frame("f1", {D1, D2, D3, D4, D5, D9}, 6'b000000, 0, 5, 3, 24'h123500);
    // Frames 2 and 3: blink on, colons at idx 2 and 4.
    run_frame("f2", {D1, D2, D3, D5, D0, D0}, 6'b010100, 0, 5, -1, 24'h0);
    chk("f2_err", bus.err, 1'b0);
    run_frame("f3", {D1, D2, D3, D5, D0, D0}, 6'b010100, 0, 5, 0, 24'h123B00);
    // Frame 4: illegal m1 captured, blink off; m1 returns to 5.
    run_frame("f4", {D1, D2, D3, DASH, D0, D0}, 6'b000000, 0, 5, 0, 24'h123500);
    chk("f4_err", bus.err, 1'b1);
    // Frame 5: legal snapshot again, err stays set.
    run_frame("f5", {D1, D2, D3, D5, D0, D0}, 6'b000000, 0, 3, -1, 24'h0);
    chk("f5_err", bus.err, 1'b1);

    // Enable gating at idx 4, div 1.
    step(1);
    chk("en_pre_anode", bus.anode, 6'b101111);
    bus.en = 1'b0;
    step(1);
    chk("en_off_anode", bus.anode, 6'b111111);
    chk("en_off_seg", bus.seg, OFF);
    chk("en_off_dp", bus.dp, 1'b1);
    step(9);
    chk("en_off_hold", bus.anode, 6'b111111);
    bus.en = 1'b1;
    step(1);
    chk("en_on_anode", bus.anode, 6'b101111);
    chk("en_on_seg", bus.seg, D2);
    chk("en_on_dp", bus.dp, 1'b1);
    step(2);
    chk("en_on_hold", bus.anode, 6'b101111);
    step(1);
    chk("en_on_next_anode", bus.anode, 6'b011111);
    chk("en_on_next_seg", bus.seg, D1);
    chk("en_err_kept", bus.err, 1'b1);

    // Only reset clears err.
    rst_n = 1'b0;
    #1;
    chk("rst2_err", bus.err, 1'b0);
    chk("rst2_anode", bus.anode, 6'b111111);

    // Leading digit with hours tens = 0.
    @(negedge clk);
    rst_n = 1'b1;
    drive(24'h090500);
`ifdef LEADING_ZERO_BLANK_EN
    lz_exp = OFF;
`else
    lz_exp = D0;
`endif
    step(45);
    chk("lz_anode", bus.anode, 6'b011111);
    chk("lz_seg", bus.seg, lz_exp);
    chk("lz_dp", bus.dp, 1'b1);
    step(4);
    chk("lz_s1_seg", bus.seg, D0);
    step(8);
    chk("lz_m1_seg", bus.seg, D5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
